// File: rtl/rsa_uart_loader.sv
// rsa_uart_loader: Avalon-MM master that pulls N, E and A (32 bytes each,
// MSB first) from a UART, starts Rsa256Core, then streams the result back.
// N and E are kept across messages; after the first block only A is reloaded.
// Optional build macro: RSA_LOADER_FULL_OUT_EN -- send all 32 result bytes
// instead of the low 31.
module rsa_uart_loader (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_n,
    output logic [255:0] o_e,
    output logic [255:0] o_a,
    input  logic [255:0] i_a_pow_e,
    input  logic         i_finished
);

`ifdef RSA_LOADER_FULL_OUT_EN
    localparam int OUT_BYTES = 32;
`else
    localparam int OUT_BYTES = 31;
`endif

    localparam logic [4:0] ADDR_RX     = 5'd0;
    localparam logic [4:0] ADDR_TX     = 5'd4;
    localparam logic [4:0] ADDR_STATUS = 5'd8;
    localparam logic [4:0] LAST_TX     = 5'(OUT_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_QRX, S_RX, S_START, S_CALC, S_QTX, S_TX
    } state_t;

    typedef enum logic [1:0] {F_N, F_E, F_A} field_t;

    state_t        state_q;
    field_t        field_q;
    logic [4:0]    cnt_q;
    logic [255:0]  res_q, n_q, e_q, a_q;
    logic [4:0]    addr_q;
    logic          rd_q, wr_q, start_q;
    logic [31:0]   wdata_q;

    logic          accept;
    logic [7:0]    rx_byte;
    logic [4:0]    tx_idx;
    logic [7:0]    tx_byte_d;
    logic          unused_rdata;

    assign avm_address   = addr_q;
    assign avm_read      = rd_q;
    assign avm_write     = wr_q;
    assign avm_writedata = wdata_q;
    assign o_core_start  = start_q;
    assign o_n           = n_q;
    assign o_e           = e_q;
    assign o_a           = a_q;

    // Only the low byte of the UART registers carries data or status flags.
    assign unused_rdata = ^avm_readdata[31:8];

    // Transaction handshake and byte selection for the current TX position.
    always_comb begin
        accept    = (rd_q | wr_q) & ~avm_waitrequest;
        rx_byte   = avm_readdata[7:0];
        tx_idx    = LAST_TX - cnt_q;
        tx_byte_d = res_q[{tx_idx, 3'b000} +: 8];
    end

    // Main loader FSM; every bus output is registered and only changes on an
    // accepted transaction, so requests stay stable under waitrequest.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            field_q <= F_N;
            cnt_q   <= 5'd0;
            res_q   <= '0;
            n_q     <= '0;
            e_q     <= '0;
            a_q     <= '0;
            addr_q  <= ADDR_STATUS;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_QRX;
                    rd_q    <= 1'b1;
                    addr_q  <= ADDR_STATUS;
                end
                S_QRX: begin
                    if (accept && avm_readdata[7]) begin
                        state_q <= S_RX;
                        addr_q  <= ADDR_RX;
                    end
                end
                S_RX: begin
                    if (accept) begin
                        case (field_q)
                            F_N:     n_q <= {n_q[247:0], rx_byte};
                            F_E:     e_q <= {e_q[247:0], rx_byte};
                            default: a_q <= {a_q[247:0], rx_byte};
                        endcase
                        // 5-bit counter wraps 31 -> 0 on its own.
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            case (field_q)
                                F_N:     field_q <= F_E;
                                default: field_q <= F_A;
                            endcase
                        end
                        addr_q <= ADDR_STATUS;
                        if (cnt_q == 5'd31 && field_q == F_A) begin
                            state_q <= S_START;
                            rd_q    <= 1'b0;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= S_QRX;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    if (i_finished) begin
                        res_q   <= i_a_pow_e;
                        cnt_q   <= 5'd0;
                        state_q <= S_QTX;
                        rd_q    <= 1'b1;
                        addr_q  <= ADDR_STATUS;
                    end
                end
                S_QTX: begin
                    if (accept && avm_readdata[6]) begin
                        state_q <= S_TX;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b1;
                        addr_q  <= ADDR_TX;
                        wdata_q <= {24'd0, tx_byte_d};
                    end
                end
                S_TX: begin
                    if (accept) begin
                        wr_q   <= 1'b0;
                        rd_q   <= 1'b1;
                        addr_q <= ADDR_STATUS;
                        if (cnt_q == LAST_TX) begin
                            field_q <= F_A;
                            cnt_q   <= 5'd0;
                            state_q <= S_QRX;
                        end else begin
                            cnt_q   <= cnt_q + 5'd1;
                            state_q <= S_QTX;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
